cache_ctrl_fsm_nway: RTL and testbench

- Parametrised controller FSM for an N-way set-associative, write-back, write-allocate cache.
- Sits between the CPU load/store port and the external tag/data arrays, the pLRU block and the line-wide memory port.
- Generalises the direct-mapped controller:
  - configurable ways, sets and line length;
  - true write-allocate, so write misses also fetch the line;
  - valid/ready memory handshake;
  - saturating statistics with clear.

---
 rtl/cache_nway_pkg.sv | 38 +++
 rtl/stat_counter_sat.sv | 37 +++
 rtl/cache_ctrl_fsm_nway.sv | 250 +++++++++++++++++++++++++
 tb/tb_cache_ctrl_fsm_nway.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_nway_pkg.sv
// Shared definitions for the N-way cache controller.
// Contents:
//   state_e         controller FSM states
//   calc_off_w      byte-offset width of a cache line
//   calc_tag_w      tag width left after index and offset
//   calc_sel_w      word-select width inside a line (at least 1 bit)
//   line_flags_t    {valid,dirty} flag pair that heads every tag entry
package cache_nway_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COMPARE    = 3'd1,
    S_WB_REQ     = 3'd2,
    S_WB_WAIT    = 3'd3,
    S_ALLOC_REQ  = 3'd4,
    S_ALLOC_WAIT = 3'd5
  } state_e;

  typedef struct packed {
    logic valid;
    logic dirty;
  } line_flags_t;

  function automatic int calc_off_w(input int line_words, input int data_w);
    return $clog2((line_words * data_w) / 8);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int sets,
                                    input int line_words, input int data_w);
    return addr_w - $clog2(sets) - calc_off_w(line_words, data_w);
  endfunction

  // A one-word line still needs a 1-bit select signal; it is forced to 0.
  function automatic int calc_sel_w(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/stat_counter_sat.sv
// 32-bit saturating event counter.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   inc_i          count one event this cycle
//   clr_i          synchronous clear; wins over inc_i
//   cnt_o          current count, sticks at 2^32-1
module stat_counter_sat (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  input  logic        clr_i,
  output logic [31:0] cnt_o
);

  logic [31:0] r_cnt;
  logic [31:0] w_cnt_next;

  always_comb begin
    w_cnt_next = r_cnt;
    if (clr_i) begin
      w_cnt_next = '0;
    end else if (inc_i && (r_cnt != 32'hFFFF_FFFF)) begin
      w_cnt_next = r_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/cache_ctrl_fsm_nway.sv
// Controller FSM for an N-way set-associative, write-back, write-allocate cache.
// Ports:
//   cpu_*        CPU load/store port; cpu_ready_o pulses once per request
//   tag_rd_i     per-way {valid,dirty,tag} of set arr_index_o (combinational)
//   data_rd_i    per-way line of set arr_index_o (combinational)
//   victim_way_i pLRU victim for arr_index_o
//   arr_*, tag_*, data_*  array write port
//   mem_req_*    line-wide memory request (valid/ready), mem_resp_* response
//   lru_*        touch pulse for the pLRU on a hit
//   clr_stats_i, no_*_o   statistics
//   dbg_state_o  current FSM state
// Handshake: a memory request transfers on a cycle where mem_req_valid_o and
// mem_req_ready_i are both 1; once raised, valid and all request fields hold
// until that cycle. mem_resp_valid_i is sampled only in the WAIT states.
module cache_ctrl_fsm_nway
  import cache_nway_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  localparam int LINE_W    = LINE_WORDS * DATA_W,
  localparam int OFF_W     = calc_off_w(LINE_WORDS, DATA_W),
  localparam int IDX_W     = $clog2(SETS),
  localparam int TAG_W     = calc_tag_w(ADDR_W, SETS, LINE_WORDS, DATA_W),
  localparam int WAY_W     = $clog2(WAYS),
  localparam int TE_W      = TAG_W + 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cpu_valid_i,
  input  logic                   cpu_rw_i,
  input  logic [ADDR_W-1:0]      cpu_addr_i,
  input  logic [DATA_W-1:0]      cpu_wdata_i,
  output logic                   cpu_ready_o,
  output logic [DATA_W-1:0]      cpu_rdata_o,
  input  logic [WAYS*TE_W-1:0]   tag_rd_i,
  input  logic [WAYS*LINE_W-1:0] data_rd_i,
  input  logic [WAY_W-1:0]       victim_way_i,
  output logic [IDX_W-1:0]       arr_index_o,
  output logic [WAY_W-1:0]       arr_way_o,
  output logic                   tag_we_o,
  output logic [TE_W-1:0]        tag_wdata_o,
  output logic                   data_we_o,
  output logic [LINE_W-1:0]      data_wdata_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic                   mem_req_rw_o,
  output logic [ADDR_W-1:0]      mem_req_addr_o,
  output logic [LINE_W-1:0]      mem_req_data_o,
  input  logic                   mem_resp_valid_i,
  input  logic [LINE_W-1:0]      mem_resp_data_i,
  output logic                   lru_update_o,
  output logic [WAY_W-1:0]       lru_way_o,
  input  logic                   clr_stats_i,
  output logic [31:0]            no_acc_o,
  output logic [31:0]            no_hit_o,
  output logic [31:0]            no_miss_o,
  output logic [31:0]            no_wb_o,
  output state_e                 dbg_state_o
);

  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int SEL_W  = calc_sel_w(LINE_WORDS);

  typedef struct packed {
    line_flags_t      flags;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  state_e             r_state, w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_rw;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_miss_seen;
  logic [WAY_W-1:0]   r_victim;

  tag_entry_t         w_entry [WAYS];
  logic [TAG_W-1:0]   w_req_tag;
  logic [SEL_W-1:0]   w_word_sel;
  logic               w_hit, w_has_inv;
  logic [WAY_W-1:0]   w_hit_way, w_inv_way, w_victim_sel;
  logic [LINE_W-1:0]  w_hit_line, w_merged_line, w_victim_line;
  tag_entry_t         w_victim_entry;
  logic               w_acc_inc, w_hit_inc, w_miss_inc, w_wb_inc;
  logic               w_unused_bits;

  // Index comes straight from the CPU while idle so the arrays are already
  // read for the latched address when COMPARE starts.
  assign arr_index_o = (r_state == S_IDLE) ? cpu_addr_i[OFF_W +: IDX_W]
                                           : r_addr[OFF_W +: IDX_W];
  assign w_req_tag   = r_addr[ADDR_W-1 -: TAG_W];
  assign w_word_sel  = (LINE_WORDS > 1) ? r_addr[BYTE_W +: SEL_W] : '0;
  assign w_unused_bits = ^r_addr[BYTE_W-1:0];

  for (genvar g = 0; g < WAYS; g++) begin : g_entry
    assign w_entry[g] = tag_entry_t'(tag_rd_i[g*TE_W +: TE_W]);
  end

  // Lowest matching way wins; lowest invalid way is the preferred victim.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit && w_entry[w].flags.valid && (w_entry[w].tag == w_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!w_has_inv && !w_entry[w].flags.valid) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
  end

  assign w_victim_sel   = w_has_inv ? w_inv_way : victim_way_i;
  assign w_hit_line     = data_rd_i[w_hit_way*LINE_W +: LINE_W];
  assign w_victim_line  = data_rd_i[r_victim*LINE_W +: LINE_W];
  assign w_victim_entry = w_entry[r_victim];

  always_comb begin
    w_merged_line = w_hit_line;
    w_merged_line[w_word_sel*DATA_W +: DATA_W] = r_wdata;
  end

  always_comb begin
    w_next          = r_state;
    cpu_ready_o     = 1'b0;
    cpu_rdata_o     = '0;
    lru_update_o    = 1'b0;
    lru_way_o       = '0;
    arr_way_o       = '0;
    tag_we_o        = 1'b0;
    tag_wdata_o     = '0;
    data_we_o       = 1'b0;
    data_wdata_o    = '0;
    mem_req_valid_o = 1'b0;
    mem_req_rw_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_data_o  = '0;
    w_acc_inc       = 1'b0;
    w_hit_inc       = 1'b0;
    w_miss_inc      = 1'b0;
    w_wb_inc        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_valid_i) begin
          w_acc_inc = 1'b1;
          w_next    = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (w_hit) begin
          cpu_ready_o  = 1'b1;
          cpu_rdata_o  = w_hit_line[w_word_sel*DATA_W +: DATA_W];
          lru_update_o = 1'b1;
          lru_way_o    = w_hit_way;
          if (r_rw) begin
            arr_way_o    = w_hit_way;
            data_we_o    = 1'b1;
            data_wdata_o = w_merged_line;
            tag_we_o     = 1'b1;
            tag_wdata_o  = {1'b1, 1'b1, w_req_tag};
          end
          // A retry after a refill was already counted as a miss.
          w_hit_inc = !r_miss_seen;
          w_next    = S_IDLE;
        end else begin
          w_miss_inc = !r_miss_seen;
          if (w_entry[w_victim_sel].flags.valid && w_entry[w_victim_sel].flags.dirty) begin
            w_next = S_WB_REQ;
          end else begin
            w_next = S_ALLOC_REQ;
          end
        end
      end
      S_WB_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_rw_o    = 1'b1;
        mem_req_addr_o  = {w_victim_entry.tag, r_addr[OFF_W +: IDX_W], {OFF_W{1'b0}}};
        mem_req_data_o  = w_victim_line;
        if (mem_req_ready_i) begin
          w_wb_inc = 1'b1;
          w_next   = S_WB_WAIT;
        end
      end
      S_WB_WAIT: begin
        if (mem_resp_valid_i) w_next = S_ALLOC_REQ;
      end
      S_ALLOC_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        if (mem_req_ready_i) w_next = S_ALLOC_WAIT;
      end
      S_ALLOC_WAIT: begin
        if (mem_resp_valid_i) begin
          arr_way_o    = r_victim;
          data_we_o    = 1'b1;
          data_wdata_o = mem_resp_data_i;
          tag_we_o     = 1'b1;
          tag_wdata_o  = {1'b1, 1'b0, w_req_tag};
          w_next       = S_COMPARE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_wdata     <= '0;
      r_miss_seen <= 1'b0;
      r_victim    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && cpu_valid_i) begin
        r_addr      <= cpu_addr_i;
        r_rw        <= cpu_rw_i;
        r_wdata     <= cpu_wdata_i;
        r_miss_seen <= 1'b0;
      end
      if (r_state == S_COMPARE && !w_hit) begin
        r_miss_seen <= 1'b1;
        r_victim    <= w_victim_sel;
      end
    end
  end

  assign dbg_state_o = r_state;

  stat_counter_sat u_cnt_acc (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(w_acc_inc), .clr_i(clr_stats_i), .cnt_o(no_acc_o)
  );
  stat_counter_sat u_cnt_hit (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(w_hit_inc), .clr_i(clr_stats_i), .cnt_o(no_hit_o)
  );
  stat_counter_sat u_cnt_miss (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(w_miss_inc), .clr_i(clr_stats_i), .cnt_o(no_miss_o)
  );
  stat_counter_sat u_cnt_wb (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(w_wb_inc), .clr_i(clr_stats_i), .cnt_o(no_wb_o)
  );

endmodule

// File: tb/tb_cache_ctrl_fsm_nway.sv
// Directed bench for cache_ctrl_fsm_nway (2 ways, 64 sets, 4-word lines).
// Tag/data arrays are modelled as bench memories; memory traffic is served
// by the access driver and logged for inspection.
module tb_cache_ctrl_fsm_nway;
  import cache_nway_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LINE_WORDS = 4;
  localparam int SETS = 64;
  localparam int WAYS = 2;
  localparam int LINE_W = 128;
  localparam int IDX_W = 6;
  localparam int TAG_W = 22;
  localparam int WAY_W = 1;
  localparam int TE_W = 24;

  logic                   clk_i, rst_ni;
  logic                   cpu_valid_i, cpu_rw_i;
  logic [ADDR_W-1:0]      cpu_addr_i;
  logic [DATA_W-1:0]      cpu_wdata_i;
  logic                   cpu_ready_o;
  logic [DATA_W-1:0]      cpu_rdata_o;
  logic [WAYS*TE_W-1:0]   tag_rd_i;
  logic [WAYS*LINE_W-1:0] data_rd_i;
  logic [WAY_W-1:0]       victim_way_i;
  logic [IDX_W-1:0]       arr_index_o;
  logic [WAY_W-1:0]       arr_way_o;
  logic                   tag_we_o;
  logic [TE_W-1:0]        tag_wdata_o;
  logic                   data_we_o;
  logic [LINE_W-1:0]      data_wdata_o;
  logic                   mem_req_valid_o, mem_req_ready_i, mem_req_rw_o;
  logic [ADDR_W-1:0]      mem_req_addr_o;
  logic [LINE_W-1:0]      mem_req_data_o;
  logic                   mem_resp_valid_i;
  logic [LINE_W-1:0]      mem_resp_data_i;
  logic                   lru_update_o;
  logic [WAY_W-1:0]       lru_way_o;
  logic                   clr_stats_i;
  logic [31:0]            no_acc_o, no_hit_o, no_miss_o, no_wb_o;
  state_e                 dbg_state_o;

  int total = 0;
  int bad = 0;

  // Hand-computed lines: word0 is the least significant word.
  localparam logic [LINE_W-1:0] LINE_A   = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
  localparam logic [LINE_W-1:0] LINE_A_S = {32'h4444_0003, 32'h3333_0002, 32'hDEAD_BEEF, 32'h1111_0000};
  localparam logic [LINE_W-1:0] LINE_1   = {32'h1300_0003, 32'h1300_0002, 32'h1300_0001, 32'h1300_0000};
  localparam logic [LINE_W-1:0] LINE_1_S = {32'h1300_0003, 32'h1300_0002, 32'hCAFE_F00D, 32'h1300_0000};
  localparam logic [LINE_W-1:0] LINE_2   = {32'h2300_0003, 32'h2300_0002, 32'h2300_0001, 32'h2300_0000};
  localparam logic [LINE_W-1:0] LINE_2_S = {32'h2300_0003, 32'h5555_AAAA, 32'h2300_0001, 32'h2300_0000};
  localparam logic [LINE_W-1:0] LINE_3   = {32'h3300_0003, 32'h3300_0002, 32'h3300_0001, 32'h3300_0000};

  logic [TE_W-1:0]   tag_mem  [WAYS][SETS] = '{default: '0};
  logic [LINE_W-1:0] data_mem [WAYS][SETS] = '{default: '0};

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } req_t;
  req_t req_log[$];
  logic [ADDR_W:0] exp_q[$];

  logic              obs_done;
  int                obs_cycles;
  logic [DATA_W-1:0] obs_rdata;
  logic              obs_lru_upd, obs_lru_way, obs_dwe, obs_twe, obs_way;
  logic [LINE_W-1:0] obs_dwdata;
  logic [TE_W-1:0]   obs_twdata;

  cache_ctrl_fsm_nway dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cpu_valid_i(cpu_valid_i), .cpu_rw_i(cpu_rw_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_ready_o(cpu_ready_o), .cpu_rdata_o(cpu_rdata_o),
    .tag_rd_i(tag_rd_i), .data_rd_i(data_rd_i), .victim_way_i(victim_way_i),
    .arr_index_o(arr_index_o), .arr_way_o(arr_way_o),
    .tag_we_o(tag_we_o), .tag_wdata_o(tag_wdata_o),
    .data_we_o(data_we_o), .data_wdata_o(data_wdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_rw_o(mem_req_rw_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_data_o(mem_req_data_o), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_data_i(mem_resp_data_i), .lru_update_o(lru_update_o),
    .lru_way_o(lru_way_o), .clr_stats_i(clr_stats_i),
    .no_acc_o(no_acc_o), .no_hit_o(no_hit_o), .no_miss_o(no_miss_o), .no_wb_o(no_wb_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- array model and request log ----------------
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      tag_rd_i[w*TE_W +: TE_W]      = tag_mem[w][arr_index_o];
      data_rd_i[w*LINE_W +: LINE_W] = data_mem[w][arr_index_o];
    end
  end

  always @(posedge clk_i) begin
    if (tag_we_o)  tag_mem[arr_way_o][arr_index_o]  <= tag_wdata_o;
    if (data_we_o) data_mem[arr_way_o][arr_index_o] <= data_wdata_o;
    if (rst_ni && mem_req_valid_o && mem_req_ready_i)
      req_log.push_back('{rw: mem_req_rw_o, addr: mem_req_addr_o, data: mem_req_data_o});
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    cpu_valid_i = 1'b0; cpu_rw_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
    clr_stats_i = 1'b0;
  endtask

  // Issues one request at a falling edge, serves memory with zero stall and
  // one-cycle response, and records what the DUT showed on completion.
  task automatic run_access(input logic rw, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [LINE_W-1:0] refill);
    logic resp_next, resp_rw;
    resp_next = 1'b0; resp_rw = 1'b0; obs_done = 1'b0; obs_cycles = 0;
    cpu_valid_i = 1'b1; cpu_rw_i = rw; cpu_addr_i = addr; cpu_wdata_i = wdata;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      cpu_valid_i = 1'b0; cpu_addr_i = 32'hFFFF_FFF0; cpu_wdata_i = '0;
      mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
      if (resp_next) begin
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = resp_rw ? '0 : refill;
        resp_next = 1'b0;
      end else if (cpu_ready_o) begin
        obs_cycles = c + 1;
        obs_rdata = cpu_rdata_o; obs_lru_upd = lru_update_o; obs_lru_way = lru_way_o;
        obs_dwe = data_we_o; obs_dwdata = data_wdata_o; obs_twe = tag_we_o;
        obs_twdata = tag_wdata_o; obs_way = arr_way_o;
        obs_done = 1'b1;
        break;
      end else if (mem_req_valid_o) begin
        mem_req_ready_i = 1'b1;
        resp_next = 1'b1;
        resp_rw = mem_req_rw_o;
      end
    end
    total++;
    if (obs_done !== 1'b1) begin
      bad++;
      $display("FAIL access_timeout addr=%h: no cpu_ready_o within 200 cycles", addr);
    end
    @(negedge clk_i);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    victim_way_i = '0;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    total++;
    if ({cpu_ready_o, mem_req_valid_o, tag_we_o, data_we_o, lru_update_o} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got=%b want=00000",
                      {cpu_ready_o, mem_req_valid_o, tag_we_o, data_we_o, lru_update_o});
    end
    total++;
    if ({no_acc_o, no_hit_o, no_miss_o, no_wb_o} !== 128'd0) begin
      bad++; $display("FAIL reset_counters got=%h want=0", {no_acc_o, no_hit_o, no_miss_o, no_wb_o});
    end
    total++;
    if (dbg_state_o !== S_IDLE) begin
      bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state_o, S_IDLE);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    // A stray response while idle must not move the FSM or write the arrays.
    mem_resp_valid_i = 1'b1; mem_resp_data_i = {LINE_W{1'b1}};
    total++;
    if (data_we_o !== 1'b0) begin
      bad++; $display("FAIL stray_resp_we got=%b want=0", data_we_o);
    end
    @(negedge clk_i);
    mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
    total++;
    if (dbg_state_o !== S_IDLE) begin
      bad++; $display("FAIL stray_resp_state got=%0d want=%0d", dbg_state_o, S_IDLE);
    end
  endtask

  task automatic test_cold_load();
    req_t r;
    logic [ADDR_W:0] e;
    req_log.delete();
    exp_q.push_back({1'b0, 32'h0000_0100});
    run_access(1'b0, 32'h0000_0104, '0, LINE_A);
    total++;
    if (obs_rdata !== 32'h2222_0001) begin
      bad++; $display("FAIL cold_rdata got=%h want=22220001", obs_rdata);
    end
    total++;
    if ({no_acc_o, no_hit_o, no_miss_o} !== {32'd1, 32'd0, 32'd1}) begin
      bad++; $display("FAIL cold_counters acc=%0d hit=%0d miss=%0d want 1/0/1", no_acc_o, no_hit_o, no_miss_o);
    end
    total++;
    if (tag_mem[0][16] !== {2'b10, 22'd0}) begin
      bad++; $display("FAIL cold_tag got=%h want=%h", tag_mem[0][16], {2'b10, 22'd0});
    end
    total++;
    if (req_log.size() != exp_q.size()) begin
      bad++; $display("FAIL cold_req_count got=%0d want=%0d", req_log.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        r = req_log.pop_front();
        if ({r.rw, r.addr} !== e) begin
          bad++; $display("FAIL cold_req got=%h want=%h", {r.rw, r.addr}, e);
        end
      end
    end
    exp_q.delete();
    req_log.delete();
    run_access(1'b0, 32'h0000_0108, '0, '0);
    total++;
    if ({obs_cycles, obs_rdata} !== {32'd1, 32'h3333_0002}) begin
      bad++; $display("FAIL warm_hit cycles=%0d rdata=%h want 1/33330002", obs_cycles, obs_rdata);
    end
    total++;
    if ({no_hit_o, 32'(req_log.size())} !== {32'd1, 32'd0}) begin
      bad++; $display("FAIL warm_hit_stats hit=%0d reqs=%0d want 1/0", no_hit_o, req_log.size());
    end
  endtask

  task automatic test_store_hit();
    req_log.delete();
    run_access(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, '0);
    total++;
    if ({obs_dwe, obs_dwdata} !== {1'b1, LINE_A_S}) begin
      bad++; $display("FAIL store_hit_data we=%b got=%h want=%h", obs_dwe, obs_dwdata, LINE_A_S);
    end
    total++;
    if ({obs_twe, obs_twdata, obs_way} !== {1'b1, 2'b11, 22'd0, 1'b0}) begin
      bad++; $display("FAIL store_hit_tag we=%b tag=%h way=%b", obs_twe, obs_twdata, obs_way);
    end
    total++;
    if ({obs_lru_upd, obs_lru_way, obs_cycles} !== {1'b1, 1'b0, 32'd1}) begin
      bad++; $display("FAIL store_hit_lru upd=%b way=%b cycles=%0d want 1/0/1", obs_lru_upd, obs_lru_way, obs_cycles);
    end
    total++;
    if (req_log.size() != 0) begin
      bad++; $display("FAIL store_hit_traffic got=%0d requests want=0", req_log.size());
    end
  endtask

  task automatic test_store_miss();
    req_log.delete();
    run_access(1'b1, 32'h0000_0404, 32'hCAFE_F00D, LINE_1);
    total++;
    if (req_log.size() != 1 || {req_log[0].rw, req_log[0].addr} !== {1'b0, 32'h0000_0400}) begin
      bad++; $display("FAIL store_miss_req count=%0d want one read of 00000400", req_log.size());
    end
    total++;
    if (data_mem[0][0] !== LINE_1_S) begin
      bad++; $display("FAIL store_miss_line got=%h want=%h", data_mem[0][0], LINE_1_S);
    end
    total++;
    if ({tag_mem[0][0], no_miss_o} !== {2'b11, 22'd1, 32'd2}) begin
      bad++; $display("FAIL store_miss_tag tag=%h miss=%0d want c00001/2", tag_mem[0][0], no_miss_o);
    end
  endtask

  task automatic test_writeback();
    run_access(1'b1, 32'h0000_0808, 32'h5555_AAAA, LINE_2);
    total++;
    if ({tag_mem[1][0], data_mem[1][0]} !== {2'b11, 22'd2, LINE_2_S}) begin
      bad++; $display("FAIL wb_fill_way1 tag=%h line=%h", tag_mem[1][0], data_mem[1][0]);
    end
    victim_way_i = 1'b1;
    req_log.delete();
    run_access(1'b0, 32'h0000_0C00, '0, LINE_3);
    victim_way_i = 1'b0;
    total++;
    if (req_log.size() != 2) begin
      bad++; $display("FAIL wb_req_count got=%0d want=2", req_log.size());
    end else begin
      if (req_log[0] !== '{rw: 1'b1, addr: 32'h0000_0800, data: LINE_2_S}) begin
        bad++; $display("FAIL wb_req_first rw=%b addr=%h data=%h want 1/00000800/%h",
                        req_log[0].rw, req_log[0].addr, req_log[0].data, LINE_2_S);
      end
      if ({req_log[1].rw, req_log[1].addr} !== {1'b0, 32'h0000_0C00}) begin
        bad++; $display("FAIL wb_req_second rw=%b addr=%h want 0/00000c00", req_log[1].rw, req_log[1].addr);
      end
    end
    total++;
    if ({obs_rdata, tag_mem[1][0]} !== {32'h3300_0000, 2'b10, 22'd3}) begin
      bad++; $display("FAIL wb_refill rdata=%h tag=%h", obs_rdata, tag_mem[1][0]);
    end
    total++;
    if ({no_acc_o, no_hit_o, no_miss_o, no_wb_o} !== {32'd6, 32'd2, 32'd4, 32'd1}) begin
      bad++; $display("FAIL wb_counters acc=%0d hit=%0d miss=%0d wb=%0d want 6/2/4/1",
                      no_acc_o, no_hit_o, no_miss_o, no_wb_o);
    end
  endtask

  task automatic test_stall_reset();
    logic seen;
    seen = 1'b0;
    // Set 0 holds tag 1 (dirty, way 0) and tag 3 (clean, way 1); victim way 0.
    victim_way_i = 1'b0;
    cpu_valid_i = 1'b1; cpu_rw_i = 1'b0; cpu_addr_i = 32'h0000_1000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      cpu_valid_i = 1'b0; cpu_addr_i = '0;
      if (mem_req_valid_o) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL stall_no_request within 10 cycles");
    end
    for (int c = 0; c < 5; c++) begin
      total++;
      if ({mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_req_data_o} !==
          {1'b1, 1'b1, 32'h0000_0400, LINE_1_S}) begin
        bad++; $display("FAIL stall_hold cycle=%0d valid=%b rw=%b addr=%h data=%h",
                        c, mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_req_data_o);
      end
      @(negedge clk_i);
    end
    rst_ni = 1'b0;
    #1;
    total++;
    if (mem_req_valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_drop_valid got=%b want=0", mem_req_valid_o);
    end
    total++;
    if ({no_acc_o, no_hit_o, no_miss_o, no_wb_o, dbg_state_o} !== {128'd0, S_IDLE}) begin
      bad++; $display("FAIL reset_mid_op counters=%h state=%0d", {no_acc_o, no_hit_o, no_miss_o, no_wb_o}, dbg_state_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_saturation();
    force dut.u_cnt_acc.r_cnt = 32'hFFFF_FFFE;
    @(negedge clk_i);
    release dut.u_cnt_acc.r_cnt;
    @(negedge clk_i);
    total++;
    if (no_acc_o !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL sat_preload got=%h want=fffffffe", no_acc_o);
    end
    run_access(1'b0, 32'h0000_0108, '0, '0);
    total++;
    if (no_acc_o !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL sat_reach got=%h want=ffffffff", no_acc_o);
    end
    run_access(1'b0, 32'h0000_0108, '0, '0);
    total++;
    if (no_acc_o !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL sat_hold got=%h want=ffffffff", no_acc_o);
    end
    cpu_valid_i = 1'b1; cpu_rw_i = 1'b0; cpu_addr_i = 32'h0000_0108; clr_stats_i = 1'b1;
    @(negedge clk_i);
    cpu_valid_i = 1'b0; clr_stats_i = 1'b0;
    total++;
    if ({no_acc_o, no_hit_o} !== 64'd0) begin
      bad++; $display("FAIL clr_wins acc=%h hit=%h want 0/0", no_acc_o, no_hit_o);
    end
    @(negedge clk_i);
    total++;
    if ({no_hit_o, no_miss_o, dbg_state_o} !== {32'd1, 32'd0, S_IDLE}) begin
      bad++; $display("FAIL clr_after_hit hit=%0d miss=%0d state=%0d want 1/0/IDLE", no_hit_o, no_miss_o, dbg_state_o);
    end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_store_miss();
    test_writeback();
    test_stall_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
